// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_pkg
//  Brief    : Shared state encoding and default widths for mux_rr_arbiter.
//  Revision : 1.0
// ============================================================================
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int DATA_W_DEF    = 2;
  localparam int MAX_BURST_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
//  Module   : mux2
//  Brief    : Plain 2:1 data multiplexer (sel=0 -> d0, sel=1 -> d1).
//  Revision : 1.0
// ============================================================================
module mux2 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Two-way round-robin pick; rr_ptr breaks ties when both request.
//  Revision : 1.0
// ============================================================================
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic winner,
  output logic win_valid
);

  always_comb begin
    win_valid = req0 | req1;
    // A lone requester always wins; with no request the index is don't-care.
    if (req0 && req1) winner = rr_ptr;
    else              winner = req1;
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Brief    : Packet-granular round-robin arbiter sharing a 2:1 mux channel,
//             with a registered output stage. Optional counters under
//             MUX_RR_ARBITER_STATS_EN.
//  Revision : 1.0
// ============================================================================
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  if (MAX_BURST < 1 || CNT_W < 1) begin : g_param_check
    $error("mux_rr_arbiter: MAX_BURST and CNT_W must be at least 1");
  end

  arb_state_t        r_state;
  logic              r_rr_ptr;
  logic [BCNT_W-1:0] r_beat_cnt;

  logic              w_can_load;
  logic              w_acc;
  logic              w_burst_end;
  logic              w_release;
  logic              w_win;
  logic              w_win_valid;
  logic [DATA_W:0]   w_mux_beat;

  // Ready is gated by resetn so it is low during reset even before state clears.
  assign w_can_load = !out_valid || out_ready;
  assign in0_ready  = resetn && (r_state == GRANT0) && w_can_load;
  assign in1_ready  = resetn && (r_state == GRANT1) && w_can_load;

  assign w_acc       = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign w_burst_end = (r_beat_cnt == BCNT_W'(MAX_BURST - 1));
  assign w_release   = w_acc && (w_mux_beat[DATA_W] || w_burst_end);

  rr_pick2 u_pick (
    .req0      (in0_valid),
    .req1      (in1_valid),
    .rr_ptr    (r_rr_ptr),
    .winner    (w_win),
    .win_valid (w_win_valid)
  );

  mux2 #(.W(DATA_W + 1)) u_mux (
    .sel (sel),
    .d0  ({in0_last, in0_data}),
    .d1  ({in1_last, in1_data}),
    .y   (w_mux_beat)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      sel        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (w_acc) begin
        out_valid <= 1'b1;
        out_data  <= w_mux_beat[DATA_W-1:0];
        out_last  <= w_mux_beat[DATA_W] || w_burst_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_state <= w_win ? GRANT1 : GRANT0;
            sel     <= w_win;
            busy    <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (w_release) begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= (r_state == GRANT0);
          end else if (w_acc) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  logic w_idle_grant;
  assign w_idle_grant = (r_state == IDLE) && w_win_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (w_idle_grant && !w_win && grant0_cnt != '1) grant0_cnt <= grant0_cnt + 1'b1;
      if (w_idle_grant &&  w_win && grant1_cnt != '1) grant1_cnt <= grant1_cnt + 1'b1;
      if (out_valid && !out_ready && stall_cnt != '1)  stall_cnt  <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_arbiter
//  Brief    : Scoreboard bench for mux_rr_arbiter against a packet-level model.
//  Revision : 1.0
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int DW = 2;
  localparam int MB = 8;
  localparam int CW = 16;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  logic          in0_valid = 1'b0;
  logic [DW-1:0] in0_data  = '0;
  logic          in0_last  = 1'b0;
  logic          in0_ready;
  logic          in1_valid = 1'b0;
  logic [DW-1:0] in1_data  = '0;
  logic          in1_last  = 1'b0;
  logic          in1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          sel;
  logic          busy;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [CW-1:0] grant0_cnt;
  logic [CW-1:0] grant1_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  mux_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    .grant0_cnt(grant0_cnt),
    .grant1_cnt(grant1_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pending source beats per port ({last, data}) and expected output beats.
  logic [DW:0] src0[$];
  logic [DW:0] src1[$];
  logic [DW:0] exp_q[$];

  // Packet-level reference: who owns the channel, whose turn it is next,
  // how many beats the current packet has used, and whether a beat is held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_outv  = 0;
  int m_sel   = 0;
  int m_grants[2] = '{0, 0};
  int m_stalls = 0;

  // Monitor: compares the DUT against the model state before this edge.
  always @(negedge clk) begin : p_monitor
    logic [DW:0] e;
    logic        can_load;
    can_load = (m_outv == 0) || out_ready;
    chk("in0_ready", in0_ready, resetn && m_owner == 0 && can_load);
    chk("in1_ready", in1_ready, resetn && m_owner == 1 && can_load);
    chk("out_valid", out_valid, m_outv);
    chk("sel",       sel,       m_sel);
    chk("busy",      busy,      m_owner >= 0);
    if (out_valid && m_outv != 0) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL scoreboard_empty: got out_data %0h with no expected beat", out_data);
      end else begin
        e = exp_q[0];
        chk("out_data", out_data, e[DW-1:0]);
        chk("out_last", out_last, e[DW]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Model update for the coming edge, once inputs are stable.
  always @(negedge clk) begin : p_model
    int acc;
    bit rdy;
    bit lst;
    bit rel;
    logic [DW-1:0] dat;
    #1;
    acc = -1;
    if (!resetn) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_outv = 0; m_sel = 0;
      m_grants[0] = 0; m_grants[1] = 0; m_stalls = 0;
      exp_q.delete();
    end else begin
      if (m_outv != 0 && !out_ready) m_stalls++;
      rdy = (m_outv == 0) || out_ready;
      if (m_owner == 0 && in0_valid && rdy) acc = 0;
      if (m_owner == 1 && in1_valid && rdy) acc = 1;
      if (m_owner < 0) begin
        if (in0_valid || in1_valid) begin
          m_owner = (in0_valid && in1_valid) ? m_ptr : (in0_valid ? 0 : 1);
          m_sel   = m_owner;
          m_grants[m_owner]++;
        end
        if (out_ready) m_outv = 0;
      end else if (acc >= 0) begin
        dat = (acc == 1) ? in1_data : in0_data;
        lst = (acc == 1) ? in1_last : in0_last;
        rel = lst || (m_beats == MB - 1);
        exp_q.push_back({rel, dat});
        m_outv = 1;
        if (rel) begin
          m_owner = -1; m_ptr = 1 - acc; m_beats = 0;
        end else begin
          m_beats++;
        end
        if (acc == 1) void'(src1.pop_front());
        else          void'(src0.pop_front());
      end else if (out_ready) begin
        m_outv = 0;
      end
    end
  end

  task automatic step(input bit ordy, input int p0, input int p1);
    logic [DW:0] b;
    @(posedge clk); #1;
    out_ready = ordy;
    in0_valid = (src0.size() != 0) && ($urandom_range(99) < p0);
    in1_valid = (src1.size() != 0) && ($urandom_range(99) < p1);
    if (src0.size() != 0) begin b = src0[0]; in0_data = b[DW-1:0]; in0_last = b[DW]; end
    else begin in0_data = DW'($urandom); in0_last = 1'($urandom); end
    if (src1.size() != 0) begin b = src1[0]; in1_data = b[DW-1:0]; in1_last = b[DW]; end
    else begin in1_data = DW'($urandom); in1_last = 1'($urandom); end
  endtask

  task automatic push_pkt(input int port, input int len, input bit with_last);
    logic [DW:0] b;
    for (int i = 0; i < len; i++) begin
      b = {with_last && (i == len - 1), DW'($urandom)};
      if (port == 0) src0.push_back(b);
      else           src1.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    src0.delete(); src1.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic drain(input int budget, input int rp, input int p0, input int p1);
    int n;
    n = 0;
    while ((src0.size() != 0 || src1.size() != 0) && n < budget) begin
      step($urandom_range(99) < rp, p0, p1);
      n++;
    end
    n_chk++;
    if (src0.size() != 0 || src1.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d/%0d beats left expected 0/0", src0.size(), src1.size());
    end
    repeat (4) step(1'b1, 100, 100);
  endtask

  initial begin
    do_reset();

    // Single requester, 3-beat packet {1,2,3}.
    src0.push_back({1'b0, 2'd1});
    src0.push_back({1'b0, 2'd2});
    src0.push_back({1'b1, 2'd3});
    drain(50, 100, 100, 100);

    // Contention with 2-beat packets from both ports, three rounds each.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push_pkt(0, 2, 1'b1);
      push_pkt(1, 2, 1'b1);
    end
    drain(100, 100, 100, 100);

    // Backpressure: out_ready low for 4 cycles mid-packet.
    do_reset();
    push_pkt(0, 5, 1'b1);
    step(1'b1, 100, 100);
    step(1'b1, 100, 100);
    step(1'b1, 100, 100);
    repeat (4) step(1'b0, 100, 100);
    drain(50, 100, 100, 100);

    // MAX_BURST: port 1 streams 10 beats with no last; port 0 waits.
    do_reset();
    push_pkt(1, 10, 1'b0);
    step(1'b1, 100, 100);
    push_pkt(0, 1, 1'b1);
    drain(100, 100, 100, 100);

    // Reset during beat 2 of a packet, then fresh contention.
    do_reset();
    push_pkt(0, 3, 1'b1);
    repeat (3) step(1'b1, 100, 100);
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sel",       sel,       1'b0);
    chk("rst_busy",      busy,      1'b0);
    push_pkt(0, 1, 1'b1);
    push_pkt(1, 1, 1'b1);
    drain(50, 100, 100, 100);

    // Randomised packets, valid gaps and backpressure.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (src0.size() < 4) push_pkt(0, $urandom_range(1, 11), $urandom_range(9) != 0);
      if (src1.size() < 4) push_pkt(1, $urandom_range(1, 11), $urandom_range(9) != 0);
      repeat (8) step($urandom_range(99) < 70, 80, 80);
    end
    // Finish any open packet so the drain can terminate.
    src0.push_back({1'b1, 2'd0});
    src1.push_back({1'b1, 2'd0});
    drain(800, 70, 80, 80);
    chk("sb_drained", exp_q.size(), 0);

`ifdef MUX_RR_ARBITER_STATS_EN
    // Three contention rounds with injected stalls, then compare counters.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push_pkt(0, 2, 1'b1);
      push_pkt(1, 2, 1'b1);
    end
    step(1'b1, 100, 100);
    step(1'b1, 100, 100);
    repeat (2) step(1'b0, 100, 100);
    drain(100, 100, 100, 100);
    @(negedge clk);
    chk("grant0_cnt", grant0_cnt, m_grants[0]);
    chk("grant1_cnt", grant1_cnt, m_grants[1]);
    chk("stall_cnt",  stall_cnt,  m_stalls);
    chk("grant0_rounds", m_grants[0], 3);
    chk("grant1_rounds", m_grants[1], 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-wide 2:1 mux channel between two requesters (port 0, port 1), using a valid/ready handshake on each side.
- Holds its grant for a whole packet, delimited by `last` or a MAX_BURST beat limit.
- Drives the mux select and a registered output stage that feeds the downstream consumer.

Parameters:
- DATA_W, 2, width of each requester's data and of the output data.
- MAX_BURST, 8, maximum beats per grant before forced release; must be ≥1.
- CNT_W, 16, width of the statistics counters (used only when the optional feature is compiled in).

Ports:
- clk  input  1  single system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DATA_W  requester 0 data.
- in0_last  input  1  final beat of the requester 0 packet.
- in0_ready  output  1  requester 0 beat accepted this cycle.
- in1_valid / in1_data / in1_last / in1_ready: same as port 0, for requester 1.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered output data.
- out_last  output  1  registered end of packet.
- out_ready  input  1  downstream accepts the beat.
- sel  output  1  current mux select (0 = port 0, 1 = port 1); registered.
- busy  output  1  high in GRANT0 or GRANT1.

Behaviour:
- Reset is synchronous and active-low; clock is clk, reset is resetn. With resetn=0 at a clk edge:
  - state is set to IDLE; rr_ptr is set to 0 (port 0 preferred first).
  - out_valid, out_data, out_last, sel and busy are set to 0; the beat counter is set to 0.
  - in0_ready and in1_ready are 0 while in reset, because they depend on state.
- States:
  - IDLE:
    - neither valid → stay in IDLE.
    - only inN_valid → go to GRANTN.
    - both valid → go to GRANT[rr_ptr].
    - sel is updated to the winner on the same edge.
  - GRANTN:
    - inN_ready = (!out_valid || out_ready); the other port's ready = 0.
    - Each accepted beat (inN_valid && inN_ready) loads out_data, out_last and out_valid=1 on the next edge; beat counter increments.
    - Release on the accepted beat where inN_last=1 or the beat counter reaches MAX_BURST-1. On release:
      - next state is IDLE, beat counter is cleared, rr_ptr becomes ~N.
      - out_last is forced to 1 on a MAX_BURST release even when inN_last=0.
- Output register:
  - out_valid clears when out_ready=1 and no new beat is accepted.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Latency and throughput:
  - 1 cycle from an accepted input beat to out_valid.
  - One IDLE bubble cycle per packet switch; full throughput within a packet while out_ready=1.
- Boundary conditions:
  - inN_valid may drop mid-packet: the grant is kept, no timeout.
  - Simultaneous requests after a release: rr_ptr guarantees alternation.
  - A 1-beat packet (last on the first beat) releases immediately.
  - Reset mid-packet: the packet is dropped and all state cleared; the output beat is lost.
  - The non-granted port's valid has no effect until IDLE.

Optional Feature:
- Macro MUX_RR_ARBITER_STATS_EN.
- When defined:
  - Adds outputs grant0_cnt [CNT_W-1:0], grant1_cnt [CNT_W-1:0] and stall_cnt [CNT_W-1:0].
  - grantN_cnt counts IDLE→GRANTN transitions.
  - stall_cnt counts cycles with out_valid && !out_ready.
  - All counters saturate at all-ones and are set to 0 by reset.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mux_arb_pkg:
  - state enum: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2.
  - default width constants DATA_W_DEF=2, MAX_BURST_DEF=8.
- One natural sub-module, rr_pick2: combinational pick of the winner from (req0, req1, rr_ptr), outputting a winner index and a valid flag.
- The existing 2:1 mux is instantiated with sel for the data path into the output register.

Test Plan:
- Single requester: in0 sends a 3-beat packet {1,2,3} with last on beat 3, out_ready=1.
  - Required: out_data 1,2,3 on consecutive cycles, 1 cycle after each accept; out_last only on 3; sel=0; then IDLE.
- Contention: in0 and in1 both valid from reset, each sending 2-beat packets, repeated.
  - Required: grant order 0,1,0,1; one bubble cycle between packets; in1_ready=0 throughout GRANT0.
- Backpressure: out_ready=0 for 4 cycles mid-packet.
  - Required: out_data and out_last held stable; inN_ready=0; no beat lost or duplicated once out_ready=1.
- MAX_BURST=8 with in1 streaming 10 beats and no last.
  - Required: out_last forced on beat 8; port 0 granted next if valid; in1 regranted for beats 9–10.
- Reset mid-packet: drive resetn=0 for 1 cycle during beat 2.
  - Required: out_valid=0, sel=0, busy=0 at the next edge; the next contention goes to port 0.
- With MUX_RR_ARBITER_STATS_EN defined, run the contention test for 3 rounds.
  - Required: grant0_cnt=3, grant1_cnt=3, stall_cnt = number of injected out_ready=0 cycles.
